// File: rtl/mp1000_vram_arb_if.sv
// Bus bundle between the MP1000 VRAM arbiter, its two requesters (VDG fetch, CPU) and the RAM macro.
interface mp1000_vram_arb_if #(
  parameter int ADDR_W = 10
);
  logic              vdg_req;
  logic [ADDR_W-1:0] vdg_addr;
  logic [7:0]        vdg_data;
  logic              vdg_valid;
  logic              vdg_ovf;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vdg_data, vdg_valid, vdg_ovf, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vdg_data, vdg_valid, vdg_ovf, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mp1000_vram_arb.sv
// Single-port VRAM arbiter: VDG fetch has priority, CPU served otherwise.
// Define VRAM_ARB_STARVE_EN to compile in the CPU starvation guard (cpu_wait counter).
module mp1000_vram_arb #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk_sys,
  input logic              reset,
  mp1000_vram_arb_if.slave bus
);
  // state      | meaning
  // S_IDLE     | CPU may become a candidate when cpu_req=1
  // S_GRANTED  | CPU access is on the RAM port this cycle
  // S_WAIT_ACK | CPU read in flight, waiting for its data cycle
  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_WAIT_ACK} cpu_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VDG, TAG_CPU_RD, TAG_CPU_WR} tag_t;

  cpu_state_t        state_q, state_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q, tag2_d;
  logic              vdg_pend_q, vdg_pend_d;
  logic [ADDR_W-1:0] vdg_paddr_q, vdg_paddr_d;
  logic              vdg_ovf_q, vdg_ovf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;

  logic cpu_cand;
  logic starve_fire;
  logic vdg_grant;
  logic cpu_grant;
  logic vdg_valid;
  logic cpu_ack;

  assign cpu_cand = (state_q == S_IDLE) && bus.cpu_req;

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
  logic [3:0] cpu_wait_q, cpu_wait_d;

  assign starve_fire = cpu_cand && (cpu_wait_q >= STARVE_LIM4);

  always_comb begin
    cpu_wait_d = cpu_wait_q;
    if (cpu_grant) begin
      cpu_wait_d = 4'd0;
    end else if (cpu_cand && (cpu_wait_q != 4'd15)) begin
      cpu_wait_d = cpu_wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_wait_q <= 4'd0;
    end else begin
      cpu_wait_q <= cpu_wait_d;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  assign vdg_grant = vdg_pend_q && !starve_fire;
  assign cpu_grant = cpu_cand && !vdg_grant;

  // Write acks with the RAM write itself; read data returns one stage later.
  assign vdg_valid     = (tag2_q == TAG_VDG);
  assign cpu_ack       = (tag1_q == TAG_CPU_WR) || (tag2_q == TAG_CPU_RD);
  assign bus.vdg_valid = vdg_valid;
  assign bus.vdg_data  = vdg_valid ? bus.ram_rdata : 8'h00;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_rdata = (tag2_q == TAG_CPU_RD) ? bus.ram_rdata : 8'h00;
  assign bus.vdg_ovf   = vdg_ovf_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = TAG_NONE;
    tag2_d      = tag1_q;
    if (vdg_grant) begin
      ram_addr_d = vdg_paddr_q;
      tag1_d     = TAG_VDG;
    end else if (cpu_grant) begin
      ram_addr_d  = bus.cpu_addr;
      ram_we_d    = bus.cpu_we;
      ram_wdata_d = bus.cpu_wdata;
      tag1_d      = bus.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    end
  end

  // A new pulse may refill the slot in the same cycle its occupant is granted.
  always_comb begin
    vdg_pend_d  = vdg_pend_q && !vdg_grant;
    vdg_paddr_d = vdg_paddr_q;
    vdg_ovf_d   = vdg_ovf_q;
    if (bus.vdg_req) begin
      if (!vdg_pend_q || vdg_grant) begin
        vdg_pend_d  = 1'b1;
        vdg_paddr_d = bus.vdg_addr;
      end else begin
        vdg_ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cpu_grant) state_d = S_GRANTED;
      S_GRANTED:  state_d = cpu_ack ? S_IDLE : S_WAIT_ACK;
      S_WAIT_ACK: if (cpu_ack) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      vdg_pend_q  <= 1'b0;
      vdg_paddr_q <= '0;
      vdg_ovf_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      vdg_pend_q  <= vdg_pend_d;
      vdg_paddr_q <= vdg_paddr_d;
      vdg_ovf_q   <= vdg_ovf_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end
endmodule

// File: tb/tb_mp1000_vram_arb.sv
// Directed bench for mp1000_vram_arb with a behavioural synchronous RAM.
module tb_mp1000_vram_arb;
  logic clk_sys = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_sys = ~clk_sys;

  mp1000_vram_arb_if #(.ADDR_W(10)) bus ();

  mp1000_vram_arb #(.ADDR_W(10), .STARVE_LIMIT(8)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  function automatic logic [7:0] init_val(input logic [9:0] a);
    if (a == 10'h123) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] mem [0:1023];
  bit         written [0:1023];

  always @(posedge clk_sys) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_wdata;
      written[bus.ram_addr] <= 1'b1;
    end
    bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : init_val(bus.ram_addr);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vdg_valid"}, 32'(bus.vdg_valid), 0);
    chk({tag, "_vdg_data"},  32'(bus.vdg_data),  0);
    chk({tag, "_vdg_ovf"},   32'(bus.vdg_ovf),   0);
    chk({tag, "_cpu_ack"},   32'(bus.cpu_ack),   0);
    chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
    chk({tag, "_ram_we"},    32'(bus.ram_we),    0);
    chk({tag, "_ram_addr"},  32'(bus.ram_addr),  0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ack_j;
    bit  exp_valid;
    int  exp_idx;
    bit  exp_ack;
    bit  exp_ovf;

    reset         = 1'b1;
    bus.vdg_req   = 1'b0;
    bus.vdg_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = 8'h00;
    step(3);
    chk_reset_outputs("rst");
    reset = 1'b0;
    step(2);

    // Single uncontended fetch: valid exactly 3 cycles after the pulse.
    bus.vdg_req  = 1'b1;
    bus.vdg_addr = 10'h123;
    step();
    bus.vdg_req = 1'b0;
    chk("fetch_n1_valid", 32'(bus.vdg_valid), 0);
    step();
    chk("fetch_n2_addr",  32'(bus.ram_addr), 32'h123);
    chk("fetch_n2_valid", 32'(bus.vdg_valid), 0);
    step();
    chk("fetch_n3_valid", 32'(bus.vdg_valid), 1);
    chk("fetch_n3_data",  32'(bus.vdg_data), 32'hA5);
    step();
    chk("fetch_n4_valid", 32'(bus.vdg_valid), 0);

    // CPU write, request held through the ack cycle.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 10'h010;
    bus.cpu_wdata = 8'h3C;
    step();
    chk("wr_ram_we",    32'(bus.ram_we), 1);
    chk("wr_ack",       32'(bus.cpu_ack), 1);
    chk("wr_ram_addr",  32'(bus.ram_addr), 32'h010);
    chk("wr_ram_wdata", 32'(bus.ram_wdata), 32'h3C);
    step();
    bus.cpu_req = 1'b0;
    chk("wr_no_second_we",  32'(bus.ram_we), 0);
    chk("wr_no_second_ack", 32'(bus.cpu_ack), 0);
    step();
    chk("wr_ram_we_idle", 32'(bus.ram_we), 0);
    chk("wr_mem_010",     32'(mem[10'h010]), 32'h3C);

    // CPU read-back.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h010;
    step();
    chk("rd_n1_ack",  32'(bus.cpu_ack), 0);
    chk("rd_n1_we",   32'(bus.ram_we), 0);
    chk("rd_n1_addr", 32'(bus.ram_addr), 32'h010);
    step();
    chk("rd_n2_ack",   32'(bus.cpu_ack), 1);
    chk("rd_n2_rdata", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_req = 1'b0;
    step();
    chk("rd_n3_ack", 32'(bus.cpu_ack), 0);

    // Same-cycle VDG pulse and CPU read: CPU goes first.
    bus.vdg_req  = 1'b1;
    bus.vdg_addr = 10'h200;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h011;
    step();
    bus.vdg_req = 1'b0;
    chk("coll_cpu_first_addr", 32'(bus.ram_addr), 32'h011);
    step();
    chk("coll_vdg_second_addr", 32'(bus.ram_addr), 32'h200);
    chk("coll_cpu_ack",         32'(bus.cpu_ack), 1);
    chk("coll_cpu_rdata",       32'(bus.cpu_rdata), 32'h4B);
    bus.cpu_req = 1'b0;
    step();
    chk("coll_vdg_valid", 32'(bus.vdg_valid), 1);
    chk("coll_vdg_data",  32'(bus.vdg_data), 32'h5A);
    chk("coll_ack_done",  32'(bus.cpu_ack), 0);
    step(3);

    // 20-pulse VDG burst with a CPU read raised one cycle in.
`ifdef VRAM_ARB_STARVE_EN
    ack_j = 11;
`else
    ack_j = 23;
`endif
    for (int j = 0; j < 26; j++) begin
`ifdef VRAM_ARB_STARVE_EN
      exp_valid = (j >= 3) && (j <= 22) && (j != 11);
      exp_idx   = (j == 12) ? 8 : j - 3;
      exp_ovf   = (j >= 10);
      if (j == 10) chk("starve_cpu_addr", 32'(bus.ram_addr), 32'h0F0);
      if (j == 11) chk("starve_vdg_next_addr", 32'(bus.ram_addr), 32'h308);
`else
      exp_valid = (j >= 3) && (j <= 22);
      exp_idx   = j - 3;
      exp_ovf   = 1'b0;
      if (j == 22) chk("burst_cpu_addr", 32'(bus.ram_addr), 32'h0F0);
`endif
      exp_ack = (j == ack_j);
      chk($sformatf("burst_valid_j%0d", j), 32'(bus.vdg_valid), 32'(exp_valid));
      if (exp_valid)
        chk($sformatf("burst_data_j%0d", j), 32'(bus.vdg_data),
            32'(init_val(10'(32'h300 + exp_idx))));
      chk($sformatf("burst_ack_j%0d", j), 32'(bus.cpu_ack), 32'(exp_ack));
      if (exp_ack)
        chk("burst_cpu_rdata", 32'(bus.cpu_rdata), 32'hAA);
      chk($sformatf("burst_ovf_j%0d", j), 32'(bus.vdg_ovf), 32'(exp_ovf));

      bus.vdg_req  = (j < 20);
      bus.vdg_addr = 10'(32'h300 + j);
      if (j == 1) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h0F0;
      end
      if (j == ack_j) bus.cpu_req = 1'b0;
      step();
    end
    step(4);
`ifdef VRAM_ARB_STARVE_EN
    chk("ovf_sticky", 32'(bus.vdg_ovf), 1);
`else
    chk("ovf_never_set", 32'(bus.vdg_ovf), 0);
`endif

    // Reset in the cycle after a CPU read grant.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h123;
    step();
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    chk_reset_outputs("midrd");
    reset = 1'b0;
    step();
    chk("midrd_post_ack",   32'(bus.cpu_ack), 0);
    chk("midrd_post_valid", 32'(bus.vdg_valid), 0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h010;
    step();
    chk("after_rst_n1_ack", 32'(bus.cpu_ack), 0);
    step();
    chk("after_rst_ack",   32'(bus.cpu_ack), 1);
    chk("after_rst_rdata", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_req = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
